instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/instruction_fetch.sv | 166 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, the NOP
// instruction word and the default reset PC.
// Optional feature macro: IF_MISALIGN_CHECK_EN (adds the HALT state).
package cpu_pkg;

`ifdef IF_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;
`else
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } fetch_state_t;
`endif

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect / +4 advance / hold selection.
// Redirect has priority over advance; the pc wraps modulo 2^32 silently.
module fetch_pc_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        advance_en,
   output logic [31:0] pc
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Next-pc select: redirect target, sequential advance, or hold.
   always_comb begin
      pc_d = pc_q;
      if (redirect_en) begin
         pc_d = redirect_pc;
      end else if (advance_en) begin
         pc_d = pc_q + 32'd4;
      end
   end

   // PC state register, asynchronously reset to the boot address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: presents the pc to instruction memory, registers
// the returned word for decode, handles stalls and redirects, and counts
// completed transfers.
// Handshake: a transfer happens on every rising edge where if_valid and
// id_ready are both 1; while if_valid=1 and id_ready=0 the output register
// (if_instr, if_pc, if_valid) and the pc stay frozen.
// Optional feature macro: IF_MISALIGN_CHECK_EN adds output if_misaligned
// and a HALT state entered on a misaligned redirect; without it the low two
// bits of redirect_pc are forced to zero.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_valid,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_count,
`ifdef IF_MISALIGN_CHECK_EN
   output logic        if_misaligned,
`endif
   output logic [1:0]  dbg_state
);

   fetch_state_t state_q;
   fetch_state_t state_d;
   logic [31:0]  if_instr_q;
   logic [31:0]  if_instr_d;
   logic [31:0]  if_pc_q;
   logic [31:0]  if_pc_d;
   logic         if_valid_q;
   logic         if_valid_d;
   logic [31:0]  fetch_count_q;
   logic [31:0]  fetch_count_d;
`ifdef IF_MISALIGN_CHECK_EN
   logic         misaligned_q;
   logic         misaligned_d;
`endif

   logic [31:0]  pc;
   logic         pc_redirect;
   logic         pc_advance;
   logic [31:0]  redirect_target;
   logic         transfer;

`ifdef IF_MISALIGN_CHECK_EN
   assign redirect_target = redirect_pc;
`else
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

   assign transfer = if_valid_q & id_ready;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .reset       (reset),
      .redirect_en (pc_redirect),
      .redirect_pc (redirect_target),
      .advance_en  (pc_advance),
      .pc          (pc)
   );

   // FSM next state, output-register load, pc control and transfer counting.
   always_comb begin
      state_d       = state_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_valid_d    = if_valid_q;
      fetch_count_d = fetch_count_q;
      pc_redirect   = 1'b0;
      pc_advance    = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misaligned_d  = misaligned_q;
`endif
      case (state_q)
`ifdef IF_MISALIGN_CHECK_EN
         ST_HALT: begin
            // Frozen until reset; redirects are ignored.
            state_d = ST_HALT;
         end
`endif
         ST_BOOT, ST_RUN, ST_STALL: begin
            // The decoder accepts whatever is on the outputs this edge,
            // even if a redirect flushes the word arriving from memory.
            if (transfer) begin
               fetch_count_d = fetch_count_q + 32'd1;
            end
            if (redirect_valid) begin
               if_valid_d = 1'b0;
               state_d    = ST_RUN;
`ifdef IF_MISALIGN_CHECK_EN
               if (redirect_pc[1:0] != 2'b00) begin
                  misaligned_d = 1'b1;
                  state_d      = ST_HALT;
               end else begin
                  pc_redirect = 1'b1;
               end
`else
               pc_redirect = 1'b1;
`endif
            end else if (state_q == ST_BOOT) begin
               // One idle cycle after reset before the first fetch is captured.
               state_d = ST_RUN;
            end else if (!if_valid_q || id_ready) begin
               if_instr_d = imem_rdata;
               if_pc_d    = pc;
               if_valid_d = 1'b1;
               pc_advance = 1'b1;
               state_d    = ST_RUN;
            end else begin
               state_d = ST_STALL;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State, output register and counter flops with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         if_instr_q    <= NOP_INSTR;
         if_pc_q       <= 32'h0000_0000;
         if_valid_q    <= 1'b0;
         fetch_count_q <= 32'h0000_0000;
      end else begin
         state_q       <= state_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         if_valid_q    <= if_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   // Sticky misaligned-redirect flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= misaligned_d;
      end
   end

   assign if_misaligned = misaligned_q;
`endif

   assign imem_addr   = pc;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_valid    = if_valid_q;
   assign fetch_count = fetch_count_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: boot sequence, stall, redirect
// while stalled, pc wrap (second instance), asynchronous reset mid-stall,
// and redirect low-bit handling (forced alignment, or halt when
// IF_MISALIGN_CHECK_EN is defined).
module tb_instruction_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] fetch_count;
   logic [1:0]  dbg_state;
`ifdef IF_MISALIGN_CHECK_EN
   logic        if_misaligned;
   logic        w_if_misaligned;
`endif

   // Second instance for the pc wrap scenario.
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic [31:0] w_if_instr;
   logic [31:0] w_if_pc;
   logic        w_if_valid;
   logic [31:0] w_fetch_count;
   logic [1:0]  w_dbg_state;

   logic [31:0] mem [0:63];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata   = mem[imem_addr[7:2]];
   assign w_imem_rdata = w_imem_addr ^ 32'hA5A5_A5A5;

   instruction_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_valid       (if_valid),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_count    (fetch_count),
`ifdef IF_MISALIGN_CHECK_EN
      .if_misaligned  (if_misaligned),
`endif
      .dbg_state      (dbg_state)
   );

   instruction_fetch #(
      .RESET_PC (32'hFFFF_FFF8)
   ) dut_wrap (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (w_imem_addr),
      .imem_rdata     (w_imem_rdata),
      .if_instr       (w_if_instr),
      .if_pc          (w_if_pc),
      .if_valid       (w_if_valid),
      .id_ready       (1'b1),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0000_0000),
      .fetch_count    (w_fetch_count),
`ifdef IF_MISALIGN_CHECK_EN
      .if_misaligned  (w_if_misaligned),
`endif
      .dbg_state      (w_dbg_state)
   );

   // Comparison point
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Driver: advance one clock, then settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
      check({tag, "_instr"}, if_instr, 32'h0000_0013);
      check({tag, "_pc"},    if_pc, 32'h0000_0000);
      check({tag, "_count"}, fetch_count, 32'd0);
      check({tag, "_addr"},  imem_addr, 32'h0000_0000);
      check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + i;
      mem[0]  = 32'h0050_0093;
      mem[1]  = 32'h00A0_0113;
      mem[2]  = 32'h00F0_0193;
      mem[20] = 32'h0062_A023;

      reset          = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #2;
      check_reset_values("rst");
`ifdef IF_MISALIGN_CHECK_EN
      check("rst_misaligned", {31'd0, if_misaligned}, 32'd0);
`endif

      @(negedge clk);
      reset = 1'b0;

      // Edge 1: BOOT bubble
      tick();
      check("boot_valid", {31'd0, if_valid}, 32'd0);
      check("boot_addr", imem_addr, 32'h0);
      check("boot_state", {30'd0, dbg_state}, 32'd1);

      // Edges 2..4: sequential fetch
      tick();
      check("f0_instr", if_instr, 32'h0050_0093);
      check("f0_pc", if_pc, 32'h0);
      check("f0_valid", {31'd0, if_valid}, 32'd1);
      check("f0_count", fetch_count, 32'd0);
      check("wrap0_pc", w_if_pc, 32'hFFFF_FFF8);
      tick();
      check("f1_instr", if_instr, 32'h00A0_0113);
      check("f1_pc", if_pc, 32'h4);
      check("f1_count", fetch_count, 32'd1);
      check("wrap1_pc", w_if_pc, 32'hFFFF_FFFC);
      tick();
      check("f2_instr", if_instr, 32'h00F0_0193);
      check("f2_pc", if_pc, 32'h8);
      check("f2_count", fetch_count, 32'd2);
      check("f2_addr", imem_addr, 32'hC);
      check("wrap2_pc", w_if_pc, 32'h0000_0000);
      check("wrap2_instr", w_if_instr, 32'hA5A5_A5A5);

      // Stall for three cycles with if_pc=8
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_instr", if_instr, 32'h00F0_0193);
         check("stall_pc", if_pc, 32'h8);
         check("stall_valid", {31'd0, if_valid}, 32'd1);
         check("stall_addr", imem_addr, 32'hC);
         check("stall_count", fetch_count, 32'd2);
         check("stall_state", {30'd0, dbg_state}, 32'd2);
      end

      // Resume: word 8 transfers, next is if_pc=12
      id_ready = 1'b1;
      tick();
      check("resume_pc", if_pc, 32'hC);
      check("resume_instr", if_instr, 32'h0100_0003);
      check("resume_count", fetch_count, 32'd3);
      check("resume_state", {30'd0, dbg_state}, 32'd1);

      // Stall again, then redirect to 0x50 while stalled
      id_ready = 1'b0;
      tick();
      check("stall2_pc", if_pc, 32'hC);
      check("stall2_state", {30'd0, dbg_state}, 32'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h50;
      tick();
      check("redir_valid", {31'd0, if_valid}, 32'd0);
      check("redir_addr", imem_addr, 32'h50);
      check("redir_count", fetch_count, 32'd3);
      check("redir_state", {30'd0, dbg_state}, 32'd1);
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      tick();
      check("tgt_pc", if_pc, 32'h50);
      check("tgt_instr", if_instr, 32'h0062_A023);
      check("tgt_valid", {31'd0, if_valid}, 32'd1);
      check("tgt_count", fetch_count, 32'd3);
      tick();
      check("tgt1_pc", if_pc, 32'h54);
      check("tgt1_count", fetch_count, 32'd4);

      // Stall, then assert reset between edges
      id_ready = 1'b0;
      tick();
      check("stall3_pc", if_pc, 32'h54);
      check("stall3_state", {30'd0, dbg_state}, 32'd2);
      #3;
      reset = 1'b1;
      #1;
      check_reset_values("midrst");

      @(negedge clk);
      reset    = 1'b0;
      id_ready = 1'b1;
      tick();
      check("reboot_valid", {31'd0, if_valid}, 32'd0);
      tick();
      check("reboot_pc", if_pc, 32'h0);
      check("reboot_instr", if_instr, 32'h0050_0093);
      check("reboot_addr", imem_addr, 32'h4);

`ifdef IF_MISALIGN_CHECK_EN
      // Misaligned redirect halts the stage
      redirect_valid = 1'b1;
      redirect_pc    = 32'h52;
      tick();
      check("mis_flag", {31'd0, if_misaligned}, 32'd1);
      check("mis_valid", {31'd0, if_valid}, 32'd0);
      check("mis_addr", imem_addr, 32'h4);
      check("mis_count", fetch_count, 32'd1);
      check("mis_state", {30'd0, dbg_state}, 32'd3);
      redirect_pc = 32'h0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("halt_addr", imem_addr, 32'h4);
         check("halt_valid", {31'd0, if_valid}, 32'd0);
         check("halt_count", fetch_count, 32'd1);
         check("halt_flag", {31'd0, if_misaligned}, 32'd1);
      end
      redirect_valid = 1'b0;
`else
      // Low two bits of the redirect target are dropped
      redirect_valid = 1'b1;
      redirect_pc    = 32'h5B;
      tick();
      check("align_valid", {31'd0, if_valid}, 32'd0);
      check("align_addr", imem_addr, 32'h58);
      check("align_count", fetch_count, 32'd1);
      redirect_valid = 1'b0;
      tick();
      check("align_pc", if_pc, 32'h58);
      check("align_instr", if_instr, 32'h0100_0016);
      check("align_count2", fetch_count, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
